if_prefetch_buffer: RTL

Instruction prefetch unit that sits directly upstream of the IF stage.
- Drives the instruction-memory request interface (instr_req/gnt/rvalid) with up to MAX_OUTSTANDING transactions in flight.
- Queues returned words in a FIFO and presents them to the IF stage through a valid/ready handshake, with the PC of each word.
- On a branch/jump redirect it flushes queued words and discards in-flight responses, then restarts fetching at the new address.

---
 rtl/if_prefetch_buffer.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/if_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// if_prefetch_buffer
//
// Instruction prefetch unit placed directly in front of the IF stage. It
// keeps up to MAX_OUTSTANDING instruction-memory transactions in flight,
// queues returned words in a FIFO_DEPTH-entry FIFO and hands them to the IF
// stage through a valid/ready handshake together with their PC. A redirect
// (branch_i) flushes the queue, discards every response still in flight and
// restarts fetching at the new target.
//
// Optional build macro:
//   IF_FIFO_BYPASS_EN - when defined, a returning word can be presented on
//                       instr_o in the same cycle it arrives, provided the
//                       FIFO is empty, nothing is being discarded and no
//                       redirect is in progress.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   fetch_en_i          allow new memory requests
//   boot_addr_i         fetch start address loaded on reset
//   branch_i            redirect pulse
//   branch_addr_i       redirect target (bits [1:0] ignored)
//   instr_req_o         memory request, held until instr_gnt_i
//   instr_addr_o        word-aligned request address
//   instr_gnt_i         request accepted
//   instr_rvalid_i      instr_rdata_i valid
//   instr_rdata_i       returned instruction word
//   valid_o             instr_o / pc_o valid towards IF
//   instr_o, pc_o       head instruction and its address
//   ready_i             IF consumes the head on valid_o & ready_i
//   busy_o              requests outstanding, discards pending or request held
// ---------------------------------------------------------------------------
module if_prefetch_buffer #(
  parameter int WORD_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en_i,
  input  logic [WORD_WIDTH-1:0] boot_addr_i,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_addr_i,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  output logic                  valid_o,
  output logic [WORD_WIDTH-1:0] instr_o,
  output logic [WORD_WIDTH-1:0] pc_o,
  input  logic                  ready_i,
  output logic                  busy_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]      CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0]      CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]      MAX_OUT_C    = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W:0]        FIFO_DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]      PTR_ZERO     = PTR_W'(0);
  localparam logic [PTR_W-1:0]      PTR_ONE      = PTR_W'(1);
  localparam logic [WORD_WIDTH-1:0] ADDR_STEP    = WORD_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REQ        = 2'd1,
    ST_FLUSH_WAIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [WORD_WIDTH-1:0] target_q, target_d;
  logic [WORD_WIDTH-1:0] head_pc_q, head_pc_d;
  logic [WORD_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      discard_q, discard_d;

  logic                  req_s, gnt_s, drop_s, push_s, pop_s;
  logic                  byp_s, byp_take_s, valid_s, issue_ok_s;
  logic [WORD_WIDTH-1:0] branch_tgt_s, instr_s;
  logic [CNT_W:0]        reserved_s;
  logic                  addr_lsb_unused_s;

  // Low address bits are architecturally ignored on both address inputs.
  assign addr_lsb_unused_s = ^{branch_addr_i[1:0], boot_addr_i[1:0]};

  // Handshake qualifiers shared by the datapath and the FSM.
  always_comb begin
    branch_tgt_s = {branch_addr_i[WORD_WIDTH-1:2], 2'b00};
    req_s        = (state_q != ST_IDLE);
    gnt_s        = req_s & instr_gnt_i;
    drop_s       = instr_rvalid_i & (discard_q != CNT_ZERO);
`ifdef IF_FIFO_BYPASS_EN
    byp_s        = instr_rvalid_i & (count_q == CNT_ZERO) &
                   (discard_q == CNT_ZERO) & ~branch_i;
`else
    byp_s        = 1'b0;
`endif
    byp_take_s   = byp_s & ready_i;
    valid_s      = (count_q != CNT_ZERO) | byp_s;
    // A pop in a redirect cycle is ignored because the FIFO is being cleared.
    pop_s        = (count_q != CNT_ZERO) & ready_i & ~branch_i;
    // A response arriving in the redirect cycle belongs to the old stream.
    push_s       = instr_rvalid_i & (discard_q == CNT_ZERO) & ~branch_i & ~byp_take_s;
  end

  // Counters, FIFO pointers/storage and the two address registers.
  always_comb begin
    outstanding_d = outstanding_q + (gnt_s ? CNT_ONE : CNT_ZERO)
                                  - (instr_rvalid_i ? CNT_ONE : CNT_ZERO);

    // On a redirect everything still in flight (including a grant in this
    // very cycle) becomes stale. A request held in FLUSH_WAIT joins the
    // discard set when it is finally granted.
    if (branch_i) begin
      discard_d = outstanding_d;
    end else begin
      discard_d = discard_q - (drop_s ? CNT_ONE : CNT_ZERO)
                + (((state_q == ST_FLUSH_WAIT) && gnt_s) ? CNT_ONE : CNT_ZERO);
    end

    fifo_d = fifo_q;
    if (push_s) begin
      fifo_d[wr_ptr_q] = instr_rdata_i;
    end else begin
      fifo_d[wr_ptr_q] = fifo_q[wr_ptr_q];
    end

    if (branch_i) begin
      count_d  = CNT_ZERO;
      rd_ptr_d = PTR_ZERO;
      wr_ptr_d = PTR_ZERO;
    end else begin
      count_d  = count_q + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
      rd_ptr_d = rd_ptr_q + (pop_s ? PTR_ONE : PTR_ZERO);
      wr_ptr_d = wr_ptr_q + (push_s ? PTR_ONE : PTR_ZERO);
    end

    if (branch_i) begin
      head_pc_d = branch_tgt_s;
    end else if (pop_s || byp_take_s) begin
      head_pc_d = head_pc_q + ADDR_STEP;
    end else begin
      head_pc_d = head_pc_q;
    end

    target_d = branch_i ? branch_tgt_s : target_q;

    // A held, ungranted request keeps its address; the target is applied
    // once that request is granted (FLUSH_WAIT).
    if (branch_i && !(req_s && !gnt_s)) begin
      fetch_addr_d = branch_tgt_s;
    end else if (gnt_s && (state_q == ST_FLUSH_WAIT)) begin
      fetch_addr_d = target_q;
    end else if (gnt_s) begin
      fetch_addr_d = fetch_addr_q + ADDR_STEP;
    end else begin
      fetch_addr_d = fetch_addr_q;
    end

    // Issue decision uses post-update occupancy so FIFO space is reserved
    // for every granted request and a push can never overflow.
    reserved_s = {1'b0, count_d} + {1'b0, outstanding_d};
    issue_ok_s = fetch_en_i & (outstanding_d < MAX_OUT_C) & (reserved_s < FIFO_DEPTH_C);
  end

  // Request FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        state_d = issue_ok_s ? ST_REQ : ST_IDLE;
      end
      ST_REQ: begin
        if (gnt_s) begin
          state_d = issue_ok_s ? ST_REQ : ST_IDLE;
        end else if (branch_i) begin
          state_d = ST_FLUSH_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_FLUSH_WAIT: begin
        if (gnt_s) begin
          state_d = issue_ok_s ? ST_REQ : ST_IDLE;
        end else begin
          state_d = ST_FLUSH_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Head-of-queue instruction, optionally taken straight from the bus.
  always_comb begin
    instr_s = {WORD_WIDTH{1'b0}};
    if (count_q != CNT_ZERO) begin
      instr_s = fifo_q[rd_ptr_q];
    end else if (byp_s) begin
      instr_s = instr_rdata_i;
    end else begin
      instr_s = {WORD_WIDTH{1'b0}};
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      fetch_addr_q  <= {boot_addr_i[WORD_WIDTH-1:2], 2'b00};
      target_q      <= {boot_addr_i[WORD_WIDTH-1:2], 2'b00};
      head_pc_q     <= {boot_addr_i[WORD_WIDTH-1:2], 2'b00};
      rd_ptr_q      <= PTR_ZERO;
      wr_ptr_q      <= PTR_ZERO;
      count_q       <= CNT_ZERO;
      outstanding_q <= CNT_ZERO;
      discard_q     <= CNT_ZERO;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= {WORD_WIDTH{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      target_q      <= target_d;
      head_pc_q     <= head_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

  assign instr_req_o  = req_s;
  assign instr_addr_o = fetch_addr_q;
  assign valid_o      = valid_s;
  assign instr_o      = instr_s;
  assign pc_o         = head_pc_q;
  assign busy_o       = (outstanding_q != CNT_ZERO) | (discard_q != CNT_ZERO) | req_s;

endmodule
